// File: rtl/arith_seq_if.sv
// Handshake and operand/result bundle between the ALU op decoder and arith_sequencer.
interface arith_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic               start;
   logic [1:0]         op;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] result;
   logic               flag;

   modport master (
      output start, op, a, b,
      input  busy, done, result, flag
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, flag
   );
endinterface

// File: rtl/arith_sequencer.sv
// Multi-cycle add/sub/mul/div sequencer built around one shared adder and one shared subtractor.
// Multiply is shift-add LSB-first, divide is restoring MSB-first, one step per clock.
module arith_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input logic        clk,
   input logic        reset,
   arith_seq_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
   typedef enum logic [1:0] {OpAdd, OpSub, OpMul, OpDiv} op_e;

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               flag_q, flag_d;

   logic [WIDTH-1:0]   add_x, add_y;
   logic [WIDTH:0]     add_out;
   logic [WIDTH:0]     sub_x, sub_y;
   logic [WIDTH+1:0]   sub_out;
   logic [WIDTH:0]     r_sh;
   logic [WIDTH-1:0]   q_sh;
   logic [2*WIDTH-1:0] p_step;
   logic [WIDTH-1:0]   mplr_step, rem_step, quo_step;
   logic [2*WIDTH-1:0] step_res;
   logic               step_flag;
   logic               unused_bits;

   // Shared adder: multiply accumulates into the upper half of P, otherwise a + b.
   always_comb begin
      add_x = opa_q;
      add_y = opb_q;
      if (op_q == OpMul) begin
         add_x = p_q[2*WIDTH-1:WIDTH];
         add_y = opa_q;
      end
      add_out = {1'b0, add_x} + {1'b0, add_y};
   end

   // Shared subtractor: WIDTH+1 wide so it also handles the shifted remainder; MSB is borrow.
   assign r_sh = {rem_q, quo_q[WIDTH-1]};
   assign q_sh = {quo_q[WIDTH-2:0], 1'b0};

   always_comb begin
      sub_x   = (op_q == OpDiv) ? r_sh : {1'b0, opa_q};
      sub_y   = {1'b0, opb_q};
      sub_out = {1'b0, sub_x} - {1'b0, sub_y};
   end

   // The bit shifted out of P and the transient top remainder bit never matter.
   assign unused_bits = ^{p_q[0], sub_out[WIDTH]};

   always_comb begin
      p_step    = mplr_q[0] ? {add_out, p_q[WIDTH-1:1]} : {1'b0, p_q[2*WIDTH-1:1]};
      mplr_step = {1'b0, mplr_q[WIDTH-1:1]};
      rem_step  = r_sh[WIDTH-1:0];
      quo_step  = q_sh;
      if (op_q == OpDiv && !sub_out[WIDTH+1]) begin
         rem_step = sub_out[WIDTH-1:0];
         quo_step = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
      end
      step_res  = '0;
      step_flag = 1'b0;
      unique case (op_q)
         OpAdd: begin
            step_res  = {{WIDTH{1'b0}}, add_out[WIDTH-1:0]};
            step_flag = add_out[WIDTH];
         end
         OpSub: begin
            step_res  = {{WIDTH{1'b0}}, sub_out[WIDTH-1:0]};
            step_flag = sub_out[WIDTH+1];
         end
         OpMul: begin
            step_res  = p_step;
            step_flag = |p_step[2*WIDTH-1:WIDTH];
         end
         OpDiv: begin
            step_res  = {rem_step, quo_step};
            step_flag = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      mplr_d   = mplr_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      result_d = result_q;
      flag_d   = flag_q;
      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (bus.start) begin
               op_d   = op_e'(bus.op);
               opa_d  = bus.a;
               opb_d  = bus.b;
               p_d    = '0;
               mplr_d = bus.b;
               rem_d  = '0;
               quo_d  = bus.a;
               if (op_e'(bus.op) == OpDiv && bus.b == '0) begin
                  state_d  = StDone;
                  result_d = {bus.a, {WIDTH{1'b1}}};
                  flag_d   = 1'b1;
               end else begin
                  state_d = StExec;
                  cnt_d   = bus.op[1] ? CntW'(WIDTH) : CntW'(1);
               end
            end
         end
         StExec: begin
            cnt_d  = cnt_q - CntW'(1);
            p_d    = p_step;
            mplr_d = mplr_step;
            rem_d  = rem_step;
            quo_d  = quo_step;
            if (cnt_q == CntW'(1)) begin
               state_d  = StDone;
               result_d = step_res;
               flag_d   = step_flag;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         op_q     <= OpAdd;
         opa_q    <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
         mplr_q   <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         result_q <= '0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         mplr_q   <= mplr_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         result_q <= result_d;
         flag_q   <= flag_d;
      end
   end

   assign bus.busy   = (state_q == StExec);
   assign bus.done   = (state_q == StDone);
   assign bus.result = result_q;
   assign bus.flag   = flag_q;
endmodule
